sw_led_bank: RTL and testbench

- Parametrised multi-channel successor to the single-switch toggle block.
- N independent switch channels, each with:
  - two-flop synchroniser;
  - counter-based debounce sampled on a shared scan tick;
  - press/release/long-press event pulses;
  - per-channel LED mode: toggle or momentary.
- Sits between board push-buttons/slide switches and user logic/LEDs on the top level.

---
 rtl/sw_led_bank.sv | 146 ++++++++++++++
 tb/tb_sw_led_bank.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_led_bank.sv
// sw_led_bank: N-channel switch front end. Each channel synchronises a raw switch,
// debounces it on a shared scan tick, emits press/release/long-press pulses and
// drives an LED in either toggle or momentary mode.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   sw[N]         raw asynchronous switch inputs
//   mode[N]       0 = LED toggles on press, 1 = LED follows debounced level
//   clr           synchronous clear of all toggle-mode LEDs
//   led[N]        LED drive
//   level[N]      debounced switch level
//   press_pulse   one-clk pulse on debounced 0->1
//   release_pulse one-clk pulse on debounced 1->0
//   long_pulse    one-clk pulse when a press has been held LONG_CNT ticks
module sw_led_bank #(
  parameter int unsigned N          = 4,
  parameter int unsigned DIV_RATIO  = 10,
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned LONG_CNT   = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic [N-1:0] mode,
  input  logic         clr,
  output logic [N-1:0] led,
  output logic [N-1:0] level,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] long_pulse
);

  localparam int unsigned DivW  = $clog2(DIV_RATIO);
  localparam int unsigned CntW  = $clog2(STABLE_CNT + 1);
  localparam int unsigned HoldW = $clog2(LONG_CNT + 1);

  localparam logic [DivW-1:0]  DivLast  = DivW'(DIV_RATIO - 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(STABLE_CNT - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CNT);
  localparam logic [HoldW-1:0] HoldPrev = HoldW'(LONG_CNT - 1);

  logic [N-1:0]     sync1_q, sync2_q;
  logic [DivW-1:0]  div_q, div_d;
  logic             tick_q, tick_d;
  logic [CntW-1:0]  cnt_q [N];
  logic [CntW-1:0]  cnt_d [N];
  logic [HoldW-1:0] hold_q [N];
  logic [HoldW-1:0] hold_d [N];
  logic [N-1:0]     level_q, level_d;
  logic [N-1:0]     press_q, press_d;
  logic [N-1:0]     release_q, release_d;
  logic [N-1:0]     long_q, long_d;
  logic [N-1:0]     led_q, led_d;

  // Scan divider: tick is registered, so it is high the cycle after div hits its last value.
  always_comb begin
    div_d  = (div_q == DivLast) ? '0 : div_q + 1'b1;
    tick_d = (div_q == DivLast);
  end

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    led_d     = led_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i]  = cnt_q[i];
      hold_d[i] = hold_q[i];
    end

    for (int i = 0; i < N; i++) begin
      // Debounce: a new level is accepted only after STABLE_CNT consecutive differing samples.
      if (tick_q) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntLast) begin
          level_d[i]   = sync2_q[i];
          cnt_d[i]     = '0;
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end

      // Hold counter looks at the registered level, so counting starts on the tick after
      // the press tick; saturation stops long_pulse from repeating.
      if (!level_q[i]) begin
        hold_d[i] = '0;
      end else if (tick_q && (hold_q[i] != HoldMax)) begin
        hold_d[i] = hold_q[i] + 1'b1;
        long_d[i] = (hold_q[i] == HoldPrev);
      end

      // Momentary LEDs ignore clr; toggle LEDs give clr priority over a press.
      if (mode[i]) begin
        led_d[i] = level_q[i];
      end else if (clr) begin
        led_d[i] = 1'b0;
      end else if (press_q[i]) begin
        led_d[i] = ~led_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      div_q     <= '0;
      tick_q    <= 1'b0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      led_q     <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sw;
      sync2_q   <= sync1_q;
      div_q     <= div_d;
      tick_q    <= tick_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      led_q     <= led_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= cnt_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign led           = led_q;
  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: tb/tb_sw_led_bank.sv
module tb_sw_led_bank;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int STB = 3;
  localparam int LNG = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw = '0;
  logic [N-1:0] mode = '0;
  logic         clr = 1'b0;
  logic [N-1:0] led, level, press_pulse, release_pulse, long_pulse;

  sw_led_bank #(
    .N(N), .DIV_RATIO(DIV), .STABLE_CNT(STB), .LONG_CNT(LNG)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .mode(mode), .clr(clr),
    .led(led), .level(level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: k counts clock edges since reset release; sw history gives the
  // synchronised value two edges late; tick falls on edges after multiples of DIV.
  int           k;
  logic [N-1:0] swq[$];
  int           m_cnt [N];
  int           m_hold[N];
  logic [N-1:0] m_lvl, m_led, m_pr, m_rl, m_lg;

  int cnt_pr[N], cnt_rl[N], cnt_lg[N], cnt_lv[N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    swq.delete();
    for (int i = 0; i < N; i++) begin
      m_cnt[i]  = 0;
      m_hold[i] = 0;
    end
    m_lvl = '0; m_led = '0; m_pr = '0; m_rl = '0; m_lg = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] syncv, old_lvl, old_pr;
    bit tk;
    k++;
    swq.push_back(sw);
    tk      = (k > 1) && ((k - 1) % DIV == 0);
    syncv   = (k >= 3) ? swq[k-3] : '0;
    old_lvl = m_lvl;
    old_pr  = m_pr;
    m_pr = '0; m_rl = '0; m_lg = '0;
    for (int i = 0; i < N; i++) begin
      if (tk) begin
        if (syncv[i] == old_lvl[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == STB - 1) begin
          m_lvl[i] = syncv[i];
          m_cnt[i] = 0;
          if (syncv[i]) m_pr[i] = 1'b1;
          else m_rl[i] = 1'b1;
        end else m_cnt[i]++;
      end
      if (!old_lvl[i]) m_hold[i] = 0;
      else if (tk && m_hold[i] < LNG) begin
        m_hold[i]++;
        if (m_hold[i] == LNG) m_lg[i] = 1'b1;
      end
      if (mode[i]) m_led[i] = old_lvl[i];
      else if (clr) m_led[i] = 1'b0;
      else if (old_pr[i]) m_led[i] = ~m_led[i];
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/led"}, led, m_led);
    chk({tag, "/level"}, level, m_lvl);
    chk({tag, "/press"}, press_pulse, m_pr);
    chk({tag, "/release"}, release_pulse, m_rl);
    chk({tag, "/long"}, long_pulse, m_lg);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      cnt_pr[i] = 0; cnt_rl[i] = 0; cnt_lg[i] = 0; cnt_lv[i] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all("cyc");
    for (int i = 0; i < N; i++) begin
      cnt_pr[i] += int'(press_pulse[i]);
      cnt_rl[i] += int'(release_pulse[i]);
      cnt_lg[i] += int'(long_pulse[i]);
      cnt_lv[i] += int'(level[i]);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int evts, lat, k_press, k_long, seg_len;
    bit found;

    // Reset with switches idle
    model_reset();
    #1 check_all("rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    evts = 0;
    repeat (100) begin
      step();
      evts += int'(|{press_pulse, release_pulse, long_pulse});
    end
    chk("idle_events", evts, 0);

    // Channel 0 toggle-mode press, release, second press
    clear_counts();
    sw[0] = 1'b1;
    found = 0; lat = 0;
    for (int c = 1; c <= 40 && !found; c++) begin
      step();
      if (level[0]) begin found = 1; lat = c; end
    end
    chk("p0_rise_found", found, 1);
    // 2 sync edges plus 3 ticks, tick phase unknown: 11..14 edges
    chk("p0_rise_latency", (lat >= 11 && lat <= 14), 1);
    run(20);
    chk("p0_press_once", cnt_pr[0], 1);
    chk("p0_led_on", led[0], 1);
    clear_counts();
    sw[0] = 1'b0;
    run(30);
    chk("p0_release_once", cnt_rl[0], 1);
    chk("p0_led_held", led[0], 1);
    sw[0] = 1'b1;
    run(30);
    chk("p0_led_off", led[0], 0);
    sw[0] = 1'b0;
    run(30);

    // Channel 1 glitch of two ticks
    clear_counts();
    sw[1] = 1'b1;
    run(8);
    sw[1] = 1'b0;
    run(30);
    chk("glitch_press", cnt_pr[1], 0);
    chk("glitch_level", cnt_lv[1], 0);
    chk("glitch_led", led[1], 0);

    // Channel 2 momentary with long press
    mode[2] = 1'b1;
    clear_counts();
    sw[2] = 1'b1;
    found = 0; k_press = 0; k_long = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (press_pulse[2]) begin found = 1; k_press = k; end
    end
    chk("p2_press_found", found, 1);
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (long_pulse[2]) begin found = 1; k_long = k; end
    end
    chk("p2_long_found", found, 1);
    chk("p2_long_delay", k_long - k_press, LNG * DIV);
    run(50 * DIV);
    chk("p2_long_once", cnt_lg[2], 1);
    chk("p2_led_follow", led[2], 1);

    // clr against a simultaneous press on channel 3
    sw[0] = 1'b1; run(30); sw[0] = 1'b0; run(30);
    sw[3] = 1'b1; run(30); sw[3] = 1'b0; run(30);
    chk("clr_pre_led0", led[0], 1);
    chk("clr_pre_led3", led[3], 1);
    sw[3] = 1'b1;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (press_pulse[3]) found = 1;
    end
    chk("clr_press_found", found, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_led0", led[0], 0);
    chk("clr_led3", led[3], 0);
    chk("clr_led2_kept", led[2], 1);
    sw[3] = 1'b0;
    run(30);

    // Asynchronous reset mid-debounce on channel 0
    sw[0] = 1'b1;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (m_cnt[0] == 2) found = 1;
    end
    chk("arst_cnt2_found", found, 1);
    chk("arst_pre_level2", level[2], 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
    found = 0; k_press = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (press_pulse[0]) begin found = 1; k_press = k; end
    end
    chk("arst_press_found", found, 1);
    chk("arst_press_edge", k_press, 3 * DIV + 1);
    run(30);
    chk("arst_press_once", cnt_pr[0], 1);

    // Randomised traffic
    for (int s = 0; s < 150; s++) begin
      sw      = N'($urandom);
      mode    = N'($urandom);
      seg_len = $urandom_range(1, 24);
      for (int c = 0; c < seg_len; c++) begin
        clr = ($urandom_range(0, 15) == 0);
        step();
      end
      clr = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
